// File: rtl/ptp_sfd_ts_fifo_if.sv
// Bundle of XGMII pass-through, RTC and timestamp FIFO signals for ptp_sfd_ts_fifo.
// The slave modport is the capture engine; the master modport is the side that drives it.
interface ptp_sfd_ts_fifo_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 80,
  parameter int SEQ_W  = 16
);
  localparam int LANES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = SEQ_W + 3 + TS_W;

  logic              clk_en_i;
  logic              dis_i;
  logic [DATA_W-1:0] xgmii_d_i;
  logic [LANES-1:0]  xgmii_c_i;
  logic [DATA_W-1:0] xgmii_d_o;
  logic [LANES-1:0]  xgmii_c_o;
  logic [TS_W-1:0]   rtc_i;
  logic              ts_valid_o;
  logic [ENT_W-1:0]  ts_data_o;
  logic              ts_pop_i;
  logic [AW:0]       ts_count_o;
  logic [7:0]        ovf_cnt_o;
  logic              ovf_clr_i;
  logic              int_en_i;
  logic [AW:0]       int_thr_i;
  logic              int_o;

  modport slave (
    input  clk_en_i, dis_i, xgmii_d_i, xgmii_c_i, rtc_i, ts_pop_i,
           ovf_clr_i, int_en_i, int_thr_i,
    output xgmii_d_o, xgmii_c_o, ts_valid_o, ts_data_o, ts_count_o,
           ovf_cnt_o, int_o
  );

  modport master (
    output clk_en_i, dis_i, xgmii_d_i, xgmii_c_i, rtc_i, ts_pop_i,
           ovf_clr_i, int_en_i, int_thr_i,
    input  xgmii_d_o, xgmii_c_o, ts_valid_o, ts_data_o, ts_count_o,
           ovf_cnt_o, int_o
  );
endinterface

// File: rtl/ptp_sfd_ts_fifo.sv
// XGMII start-of-frame timestamp capture: snapshots the RTC on FB/control in lane 0 or 4,
// tags it with a sequence number and queues it in a DEPTH-entry FIFO with a registered head.
module ptp_sfd_ts_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 80,
  parameter int SEQ_W  = 16
) (
  input  logic             xge_clk,
  input  logic             xge_rst,
  ptp_sfd_ts_fifo_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = SEQ_W + 3 + TS_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] d_o_r;
  logic [LANES-1:0]  c_o_r;
  logic              cap_vld_r;
  logic [2:0]        cap_lane_r;
  logic [TS_W-1:0]   cap_ts_r;
  logic [SEQ_W-1:0]  cap_seq_r;
  logic [SEQ_W-1:0]  seq_r;

  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       cnt_r;
  logic [ENT_W-1:0]  head_r;
  logic              valid_r;
  logic [7:0]        ovf_r;
  logic              int_r;

  logic              hit_s;
  logic [2:0]        lane_s;
  logic              det_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              wr_en_s;
  logic              drop_s;
  logic [AW-1:0]     rd_nxt_s;
  logic [AW:0]       cnt_nxt_s;
  logic [ENT_W-1:0]  wdata_s;
  logic [ENT_W-1:0]  head_nxt_s;

  // Start detect: lowest lane on a 4-lane boundary carrying control FB wins
  always_comb begin
    hit_s  = 1'b0;
    lane_s = 3'd0;
    for (int k = 0; k < LANES; k += 4) begin
      lane_s = (!hit_s && bus.xgmii_c_i[k] && (bus.xgmii_d_i[8*k +: 8] == 8'hFB)) ? 3'(k) : lane_s;
      hit_s  = hit_s | (bus.xgmii_c_i[k] && (bus.xgmii_d_i[8*k +: 8] == 8'hFB));
    end
    det_s = bus.clk_en_i & ~bus.dis_i & hit_s;
  end

  // Pass-through registers, capture stage and sequence counter, all qualified by clk_en_i
  always_ff @(posedge xge_clk or posedge xge_rst) begin
    if (xge_rst) begin
      d_o_r      <= '0;
      c_o_r      <= '1;
      cap_vld_r  <= 1'b0;
      cap_lane_r <= 3'd0;
      cap_ts_r   <= '0;
      cap_seq_r  <= '0;
      seq_r      <= '0;
    end else if (bus.clk_en_i) begin
      d_o_r     <= bus.xgmii_d_i;
      c_o_r     <= bus.xgmii_c_i;
      cap_vld_r <= det_s;
      if (det_s) begin
        cap_lane_r <= lane_s;
        cap_ts_r   <= bus.rtc_i;
        cap_seq_r  <= seq_r;
        seq_r      <= seq_r + SEQ_W'(1'b1);
      end
    end
  end

  // FIFO control; a write into the slot the read pointer lands on bypasses to the head
  always_comb begin
    push_s     = bus.clk_en_i & cap_vld_r;
    pop_s      = bus.ts_pop_i & (cnt_r != {(AW+1){1'b0}});
    full_s     = (cnt_r == FULL_CNT);
    wr_en_s    = push_s & (~full_s | pop_s);
    drop_s     = push_s & full_s & ~pop_s;
    rd_nxt_s   = rd_ptr_r + AW'(pop_s);
    cnt_nxt_s  = cnt_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
    wdata_s    = {cap_seq_r, cap_lane_r, cap_ts_r};
    head_nxt_s = (wr_en_s && (wr_ptr_r == rd_nxt_s)) ? wdata_s : mem_r[rd_nxt_s];
  end

  // FIFO storage, pointers, occupancy and registered head entry
  always_ff @(posedge xge_clk or posedge xge_rst) begin
    if (xge_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= wdata_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      rd_ptr_r <= rd_nxt_s;
      cnt_r    <= cnt_nxt_s;
      head_r   <= head_nxt_s;
      valid_r  <= (cnt_nxt_s != {(AW+1){1'b0}});
    end
  end

  // Overflow counter (clear beats increment) and occupancy interrupt
  always_ff @(posedge xge_clk or posedge xge_rst) begin
    if (xge_rst) begin
      ovf_r <= 8'd0;
      int_r <= 1'b0;
    end else begin
      if (bus.ovf_clr_i) begin
        ovf_r <= 8'd0;
      end else if (drop_s && (ovf_r != 8'hFF)) begin
        ovf_r <= ovf_r + 8'd1;
      end
      int_r <= bus.int_en_i & (cnt_r >= bus.int_thr_i) & (bus.int_thr_i != {(AW+1){1'b0}});
    end
  end

  assign bus.xgmii_d_o  = d_o_r;
  assign bus.xgmii_c_o  = c_o_r;
  assign bus.ts_valid_o = valid_r;
  assign bus.ts_data_o  = head_r;
  assign bus.ts_count_o = cnt_r;
  assign bus.ovf_cnt_o  = ovf_r;
  assign bus.int_o      = int_r;
endmodule

// File: tb/tb_ptp_sfd_ts_fifo.sv
// Directed bench for ptp_sfd_ts_fifo (64-bit, DEPTH=4) with a scoreboard queue of
// expected FIFO entries filled as start words are driven and drained on pops.
module tb_ptp_sfd_ts_fifo;
  localparam int DEPTH = 4;
  localparam logic [63:0] IDLE = 64'h0707070707070707;
  localparam logic [63:0] S0   = 64'h07070707070707FB;
  localparam logic [63:0] S4   = 64'h070707FB07070707;
  localparam logic [63:0] S04  = 64'h070707FB070707FB;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   mcount;
  int   mseq;
  int   movf;
  logic [79:0] rtc_v;
  logic [98:0] exp_q [$];
  logic [98:0] head_v;

  ptp_sfd_ts_fifo_if #(.DATA_W(64), .DEPTH(DEPTH), .TS_W(80), .SEQ_W(16)) bus ();

  ptp_sfd_ts_fifo #(.DATA_W(64), .DEPTH(DEPTH), .TS_W(80), .SEQ_W(16)) dut (
    .xge_clk (clk),
    .xge_rst (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [98:0] ent(input int seq, input int lane, input logic [79:0] ts);
    logic [15:0] s;
    logic [2:0]  l;
    s = seq[15:0];
    l = lane[2:0];
    return {s, l, ts};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [63:0] d, input logic [7:0] c, input logic en);
    bus.xgmii_d_i = d;
    bus.xgmii_c_i = c;
    bus.clk_en_i  = en;
    bus.rtc_i     = rtc_v;
  endtask

  task automatic idle(input int n);
    set_in(IDLE, 8'hFF, 1'b1);
    repeat (n) tick();
  endtask

  task automatic model_push(input int lane);
    if (mcount < DEPTH) begin
      exp_q.push_back(ent(mseq, lane, rtc_v));
      mcount++;
    end else if (movf < 255) begin
      movf++;
    end
    mseq++;
  endtask

  // One enabled word carrying a start in the given lane, then idle is presented
  task automatic start(input logic [63:0] d, input int lane);
    set_in(d, 8'hFF, 1'b1);
    tick();
    model_push(lane);
    rtc_v = rtc_v + 80'h10;
    set_in(IDLE, 8'hFF, 1'b1);
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=pop expected=empty_scoreboard", tag);
    end else begin
      head_v = exp_q.pop_front();
      check({tag, "_valid"}, bus.ts_valid_o, 1'b1);
      check(tag, bus.ts_data_o, head_v);
    end
    bus.ts_pop_i = 1'b1;
    tick();
    bus.ts_pop_i = 1'b0;
    if (mcount > 0) mcount--;
  endtask

  initial begin
    errors = 0; checks = 0; mcount = 0; mseq = 0; movf = 0;
    rtc_v = 80'h1234_5678_9ABC_0000_0010;
    rst = 1'b1;
    bus.dis_i = 1'b0; bus.ts_pop_i = 1'b0; bus.ovf_clr_i = 1'b0;
    bus.int_en_i = 1'b0; bus.int_thr_i = 3'd0;
    set_in(IDLE, 8'hFF, 1'b1);
    #1;
    check("rst_d_o", bus.xgmii_d_o, 64'd0);
    check("rst_c_o", bus.xgmii_c_o, 8'hFF);
    check("rst_valid", bus.ts_valid_o, 1'b0);
    check("rst_data", bus.ts_data_o, 99'd0);
    check("rst_count", bus.ts_count_o, 3'd0);
    check("rst_ovf", bus.ovf_cnt_o, 8'd0);
    check("rst_int", bus.int_o, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    idle(2);

    // first capture, lane 0, seq 0
    start(S0, 0);
    check("pt_d_o", bus.xgmii_d_o, S0);
    check("t1_valid_early", bus.ts_valid_o, 1'b0);
    tick();
    check("t1_valid", bus.ts_valid_o, 1'b1);
    check("t1_count", bus.ts_count_o, 3'd1);
    check("t1_data", bus.ts_data_o, ent(0, 0, 80'h1234_5678_9ABC_0000_0010));
    pop_chk("t1_pop");
    check("t1_empty", bus.ts_valid_o, 1'b0);

    // lane 4 alone, then both lanes in consecutive words
    start(S4, 4);
    start(S04, 0);
    idle(2);
    check("t2_count", bus.ts_count_o, 3'd2);
    pop_chk("t2_pop_a");
    pop_chk("t2_pop_b");

    // overflow: six starts into four slots
    for (int i = 0; i < 6; i++) start(S0, 0);
    idle(2);
    check("ovf_count", bus.ts_count_o, 3'd4);
    check("ovf_cnt", bus.ovf_cnt_o, movf[7:0]);

    // full FIFO with push and pop on the same edge
    head_v = exp_q.pop_front();
    check("fp_head", bus.ts_data_o, head_v);
    set_in(S0, 8'hFF, 1'b1);
    tick();
    exp_q.push_back(ent(mseq, 0, rtc_v));
    mseq++;
    rtc_v = rtc_v + 80'h10;
    set_in(IDLE, 8'hFF, 1'b1);
    bus.ts_pop_i = 1'b1;
    tick();
    bus.ts_pop_i = 1'b0;
    check("fp_count", bus.ts_count_o, 3'd4);
    check("fp_ovf", bus.ovf_cnt_o, movf[7:0]);
    for (int i = 0; i < 4; i++) pop_chk("fp_drain");
    check("fp_empty_cnt", bus.ts_count_o, 3'd0);
    check("fp_empty_valid", bus.ts_valid_o, 1'b0);

    // overflow clear acts with clk_en low
    bus.clk_en_i = 1'b0;
    bus.ovf_clr_i = 1'b1;
    tick();
    bus.ovf_clr_i = 1'b0;
    movf = 0;
    check("ovf_clr", bus.ovf_cnt_o, 8'd0);

    // clk_en toggling: start seen while disabled is ignored, outputs hold
    idle(1);
    set_in(S0, 8'hFF, 1'b0);
    tick();
    check("ce_hold_idle", bus.xgmii_d_o, IDLE);
    set_in(IDLE, 8'hFF, 1'b1);
    tick();
    set_in(S0, 8'hFF, 1'b1);
    tick();
    model_push(0);
    rtc_v = rtc_v + 80'h10;
    set_in(IDLE, 8'hFF, 1'b0);
    tick();
    check("ce_hold_start", bus.xgmii_d_o, S0);
    check("ce_no_write", bus.ts_count_o, 3'd0);
    set_in(IDLE, 8'hFF, 1'b1);
    tick();
    set_in(IDLE, 8'hFF, 1'b0);
    tick();
    set_in(IDLE, 8'hFF, 1'b1);
    tick();
    check("ce_count", bus.ts_count_o, 3'd1);
    pop_chk("ce_pop");

    // dis_i: no capture but data passes; a pending capture still lands
    bus.dis_i = 1'b1;
    set_in(S4, 8'hFF, 1'b1);
    tick();
    check("dis_pt", bus.xgmii_d_o, S4);
    idle(2);
    check("dis_count", bus.ts_count_o, 3'd0);
    bus.dis_i = 1'b0;
    start(S4, 4);
    bus.dis_i = 1'b1;
    idle(2);
    check("dis_pending", bus.ts_count_o, 3'd1);
    pop_chk("dis_pop");
    bus.dis_i = 1'b0;

    // interrupt at threshold 2
    bus.int_thr_i = 3'd2;
    bus.int_en_i = 1'b1;
    start(S0, 0);
    tick();
    check("int_lo_1", bus.int_o, 1'b0);
    start(S4, 4);
    tick();
    check("int_cnt2", bus.ts_count_o, 3'd2);
    check("int_lo_2", bus.int_o, 1'b0);
    tick();
    check("int_hi", bus.int_o, 1'b1);
    pop_chk("int_pop");
    check("int_cnt1", bus.ts_count_o, 3'd1);
    tick();
    check("int_lo_3", bus.int_o, 1'b0);

    // reset mid-stream with a capture in flight
    start(S0, 0);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    mcount = 0; mseq = 0; movf = 0;
    check("mrst_d_o", bus.xgmii_d_o, 64'd0);
    check("mrst_c_o", bus.xgmii_c_o, 8'hFF);
    check("mrst_valid", bus.ts_valid_o, 1'b0);
    check("mrst_data", bus.ts_data_o, 99'd0);
    check("mrst_count", bus.ts_count_o, 3'd0);
    check("mrst_int", bus.int_o, 1'b0);
    tick();
    rst = 1'b0;
    idle(2);
    check("mrst_lost", bus.ts_count_o, 3'd0);
    start(S0, 0);
    idle(2);
    pop_chk("mrst_seq0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
